fpu_io_sequencer: RTL and testbench

FPU_IO_SEQUENCER -- requirements
Module: fpu_io_sequencer

---
 rtl/fpu_io_sequencer.sv | 149 ++++++++++++++
 tb/tb_fpu_io_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_io_sequencer.sv
// fpu_io_sequencer: byte-serial host bridge to a combinational FPU.
// The host strobes in eight operand bytes plus an opcode byte. The block then waits
// FPU_LAT cycles, captures the FPU result and streams it back one byte per strobe.
// A synchronized abort (or reset) returns the block to an empty LOAD state.
module fpu_io_sequencer #(
   parameter int unsigned FPU_LAT = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] io_in,
   output logic [11:0] io_out,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [3:0]  fpu_sel,
   input  logic [31:0] fpu_y
);

   typedef enum logic [1:0] {
      LOAD  = 2'b00,
      EXEC  = 2'b01,
      DRAIN = 2'b10
   } state_t;

   logic [11:0] sync1_q, sync2_q;
   logic        strb_prev_q;
   logic [1:0]  fill_q;
   state_t      state_q;
   logic [3:0]  byte_cnt_q;
   logic [3:0]  wait_q;
   logic [1:0]  out_idx_q;
   logic [31:0] fpu_a_q, fpu_b_q, result_q;
   logic [3:0]  fpu_sel_q;
   logic        ack_q;

   logic        strb_evt;
   logic        abort_s;
   logic [7:0]  data_s;
   logic        unused_pins;

   assign abort_s     = sync2_q[10];
   assign data_s      = sync2_q[7:0];
   assign strb_evt    = sync2_q[11] & ~strb_prev_q;
   assign unused_pins = ^sync2_q[9:8];

   // Two-flop synchronizer for all pins plus the previous-strobe flop. Until the
   // synchronizer has filled with real pin samples after reset, the previous-strobe
   // flop is forced high. A strobe already high at release then looks "already seen"
   // and only a fresh low-to-high transition produces an event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q     <= 12'h000;
         sync2_q     <= 12'h000;
         strb_prev_q <= 1'b0;
         fill_q      <= 2'b00;
      end else begin
         sync1_q     <= io_in;
         sync2_q     <= sync1_q;
         strb_prev_q <= sync2_q[11] | ~fill_q[1];
         fill_q      <= {fill_q[0], 1'b1};
      end
   end

   // Sequencer: operand loading, FPU wait, result drain. Abort overrides everything.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= LOAD;
         byte_cnt_q <= 4'd0;
         wait_q     <= 4'd0;
         out_idx_q  <= 2'd0;
         fpu_a_q    <= 32'h0;
         fpu_b_q    <= 32'h0;
         fpu_sel_q  <= 4'h0;
         result_q   <= 32'h0;
         ack_q      <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         if (abort_s) begin
            state_q    <= LOAD;
            byte_cnt_q <= 4'd0;
            wait_q     <= 4'd0;
            out_idx_q  <= 2'd0;
            fpu_a_q    <= 32'h0;
            fpu_b_q    <= 32'h0;
            fpu_sel_q  <= 4'h0;
            result_q   <= 32'h0;
         end else begin
            case (state_q)
               EXEC: begin
                  if (wait_q != 4'd0) begin
                     wait_q <= wait_q - 4'd1;
                  end else begin
                     result_q  <= fpu_y;
                     out_idx_q <= 2'd0;
                     state_q   <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (strb_evt) begin
                     ack_q <= 1'b1;
                     if (out_idx_q == 2'd3) begin
                        out_idx_q  <= 2'd0;
                        byte_cnt_q <= 4'd0;
                        state_q    <= LOAD;
                     end else begin
                        out_idx_q <= out_idx_q + 2'd1;
                     end
                  end
               end
               LOAD: begin
                  if (strb_evt) begin
                     ack_q <= 1'b1;
                     if (byte_cnt_q[3]) begin
                        // Opcode byte closes the load and starts the FPU wait.
                        fpu_sel_q  <= data_s[3:0];
                        wait_q     <= 4'(FPU_LAT);
                        byte_cnt_q <= 4'd0;
                        state_q    <= EXEC;
                     end else begin
                        if (byte_cnt_q[2])
                           fpu_b_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= data_s;
                        else
                           fpu_a_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= data_s;
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                     end
                  end
               end
               default: begin
                  // Unused encoding recovers into LOAD.
                  state_q <= LOAD;
               end
            endcase
         end
      end
   end

   // Pin output decode, built only from registers.
   always_comb begin
      case (state_q)
         EXEC:    io_out = {2'b01, ack_q, 1'b0, 8'h00};
         DRAIN:   io_out = {2'b10, ack_q, 1'b1, result_q[{out_idx_q, 3'b000} +: 8]};
         default: io_out = {2'b00, ack_q, 1'b0, 4'h0, byte_cnt_q};
      endcase
   end

   assign fpu_a   = fpu_a_q;
   assign fpu_b   = fpu_b_q;
   assign fpu_sel = fpu_sel_q;

endmodule

// File: tb/tb_fpu_io_sequencer.sv
// Bench for fpu_io_sequencer: directed and randomized host transactions against a
// byte-list reference model, with the FPU itself modelled as a function.
module tb_fpu_io_sequencer;

   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] io_in;
   logic [11:0] io_out;
   logic [31:0] fpu_a, fpu_b, fpu_y;
   logic [3:0]  fpu_sel;

   int tests = 0;
   int fails = 0;

   // Reference model state.
   logic [7:0]  op [0:8];
   int          mode;    // 0 = LOAD, 1 = DRAIN
   int          bcnt;
   int          idx;
   logic [31:0] res;
   logic [7:0]  tx [0:8];

   always #5 clock = ~clock;

   fpu_io_sequencer #(.FPU_LAT(LAT)) dut (
      .clock   (clock),
      .reset   (reset),
      .io_in   (io_in),
      .io_out  (io_out),
      .fpu_a   (fpu_a),
      .fpu_b   (fpu_b),
      .fpu_sel (fpu_sel),
      .fpu_y   (fpu_y)
   );

   // Stand-in FPU: 1.0 + 2.0 gives 3.0, anything else a scrambling function.
   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] s);
      if (a == 32'h3F800000 && b == 32'h40000000 && s == 4'h1) return 32'h40400000;
      return (a + (b << 1)) ^ {8{s}};
   endfunction

   always_comb fpu_y = fpu_model(fpu_a, fpu_b, fpu_sel);

   function automatic logic [31:0] exp_a();
      return {op[3], op[2], op[1], op[0]};
   endfunction
   function automatic logic [31:0] exp_b();
      return {op[7], op[6], op[5], op[4]};
   endfunction
   function automatic logic [3:0] exp_sel();
      return op[8][3:0];
   endfunction
   function automatic logic [11:0] exp_io();
      logic [31:0] sh;
      sh = res >> (8 * idx);
      if (mode == 0) return {8'h00, 4'(bcnt)};
      return {2'b10, 1'b0, 1'b1, sh[7:0]};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 9; i++) op[i] = 8'h00;
      mode = 0; bcnt = 0; idx = 0; res = 32'h0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_io"},  32'(io_out),  32'(exp_io()));
      check({tag, "_a"},   fpu_a,        exp_a());
      check({tag, "_b"},   fpu_b,        exp_b());
      check({tag, "_sel"}, 32'(fpu_sel), 32'(exp_sel()));
   endtask

   // One strobe transfer. extra adds a second short strobe pulse that lands in EXEC
   // when d is the opcode byte; with_abort raises abort together with the strobe.
   task automatic send(input logic [7:0] d, input bit extra, input bit with_abort);
      logic [11:0] samp [1:8];
      bit accepted, last;
      accepted = !with_abort;
      last     = accepted && mode == 0 && bcnt == 8;
      @(negedge clock);
      io_in[7:0] = d;
      io_in[11]  = 1'b0;
      @(negedge clock);
      io_in[11] = 1'b1;
      if (with_abort) io_in[10] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         samp[k]   = io_out;
         io_in[11] = extra ? (k == 2) : (k < 4);
      end
      repeat (2) @(negedge clock);
      for (int k = 1; k <= 8; k++)
         check($sformatf("ack_k%0d", k), 32'(samp[k][9]), 32'(accepted && k == 3));
      if (last)
         for (int k = 3; k <= 8; k++)
            check($sformatf("code_k%0d", k), 32'(samp[k][11:10]),
                  (k < 3 + LAT + 1) ? 32'd1 : 32'd2);
      if (with_abort) begin
         clear_model();
      end else if (mode == 0) begin
         op[bcnt] = d;
         if (bcnt == 8) begin
            res  = fpu_model(exp_a(), exp_b(), exp_sel());
            mode = 1; idx = 0; bcnt = 0;
         end else begin
            bcnt++;
         end
      end else begin
         if (idx == 3) begin
            mode = 0; idx = 0; bcnt = 0;
         end else begin
            idx++;
         end
      end
      check_regs("send");
      if (with_abort) begin
         io_in[10] = 1'b0;
         repeat (3) @(negedge clock);
      end
   endtask

   task automatic transaction(input bit extra);
      for (int i = 0; i < 9; i++) send(tx[i], extra && i == 8, 1'b0);
      for (int i = 0; i < 4; i++) send(8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_abort();
      @(negedge clock);
      io_in[10] = 1'b1;
      repeat (3) @(negedge clock);
      clear_model();
      check("abort_io", 32'(io_out), 32'h0);
      check_regs("abort");
      io_in[10] = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_model();
      reset = 1'b1;
      io_in = 12'h000;
      repeat (3) @(negedge clock);
      check_regs("reset");
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Directed 1.0 + 2.0 transaction with a strobe landing in EXEC.
      tx = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40, 8'h01};
      for (int i = 0; i < 9; i++) send(tx[i], i == 8, 1'b0);
      check("drain_b0", 32'(io_out), 32'h900);
      for (int i = 0; i < 4; i++) send(8'h00, 1'b0, 1'b0);
      check("back_load", 32'(io_out), 32'h000);

      // Abort after five bytes, then a full load.
      for (int i = 0; i < 5; i++) send(tx[i], 1'b0, 1'b0);
      do_abort();
      transaction(1'b0);

      // Strobe and abort rising together.
      send(8'h5A, 1'b0, 1'b1);
      send(8'h11, 1'b0, 1'b0);
      do_abort();

      // Reset in DRAIN at index 2, strobe held high across release.
      for (int i = 0; i < 9; i++) send(tx[i], 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      send(8'h00, 1'b0, 1'b0);
      check("drain_idx2", 32'(io_out), 32'h940);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("async_reset_io", 32'(io_out), 32'h000);
      io_in[11] = 1'b1;
      clear_model();
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check($sformatf("held_strobe_k%0d", k), 32'(io_out), 32'h000);
      end
      io_in[11] = 1'b0;
      repeat (3) @(negedge clock);
      transaction(1'b1);

      // Randomized transactions.
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < 9; i++) tx[i] = 8'($urandom_range(0, 255));
         transaction(1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
